fetch_sequencer: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/branch_target_calc.sv | 29 ++
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } fetch_state_t;

    localparam int          IMM_SHIFT     = 2;
    localparam logic [63:0] PC_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC selection: sequential step, PC-relative word offset, or BR register target.
module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int PC_STEP = 4
) (
    input  logic [ADDR_W-1:0] instr_pc,
    input  logic [ADDR_W-1:0] BusImm,
    input  logic [ADDR_W-1:0] BusReg,
    input  logic              redirect_valid,
    input  logic              redirect_reg,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] imm_offset;
    logic [ADDR_W-1:0] raw_target;

    // BusImm counts words; bits shifted past the top are simply lost, and sums wrap.
    always_comb begin
        imm_offset = BusImm << IMM_SHIFT;
        raw_target = instr_pc + ADDR_W'(PC_STEP);
        if (redirect_valid) begin
            raw_target = redirect_reg ? BusReg : (instr_pc + imm_offset);
        end
        next_pc = raw_target & PC_ALIGN_MASK[ADDR_W-1:0];
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, one imem request in flight, holds the word for decode.
// Optional FETCH_PERF_EN adds perf_fetch / perf_stall event counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int PC_STEP = 4
) (
    input  logic               CLK,
    input  logic               Reset_L,
    input  logic [ADDR_W-1:0]  StartPC,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    input  logic               redirect_valid,
    input  logic               redirect_reg,
    input  logic [ADDR_W-1:0]  BusImm,
    input  logic [ADDR_W-1:0]  BusReg
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_stall
`endif
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic              boot_load;
    logic              ack_take;
    logic              handshake;

    branch_target_calc #(
        .ADDR_W (ADDR_W),
        .PC_STEP(PC_STEP)
    ) u_target (
        .instr_pc      (instr_pc),
        .BusImm        (BusImm),
        .BusReg        (BusReg),
        .redirect_valid(redirect_valid),
        .redirect_reg  (redirect_reg),
        .next_pc       (next_pc)
    );

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // An ack only counts in FETCH, so a stale ack during BOOT or HOLD is ignored.
    always_comb begin
        state_next = state;
        boot_load  = 1'b0;
        ack_take   = 1'b0;
        handshake  = 1'b0;
        case (state)
            BOOT: begin
                boot_load  = 1'b1;
                state_next = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    ack_take   = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    handshake  = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc          <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            if (boot_load) begin
                pc       <= StartPC;
                imem_req <= 1'b1;
            end
            if (ack_take) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                instr_valid <= 1'b1;
                imem_req    <= 1'b0;
            end
            if (handshake) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
                imem_req    <= 1'b1;
            end
        end
    end

    // The PC register only changes when no request is outstanding, so it doubles as the address.
    assign imem_addr = pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (handshake) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (imem_req && !imem_ack) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: next-PC vector table, hand sequences, randomized transactions.
module tb_fetch_sequencer;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    logic               CLK = 1'b0;
    logic               Reset_L = 1'b0;
    logic [ADDR_W-1:0]  StartPC = '0;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_ready = 1'b0;
    logic               redirect_valid = 1'b0;
    logic               redirect_reg = 1'b0;
    logic [ADDR_W-1:0]  BusImm = '0;
    logic [ADDR_W-1:0]  BusReg = '0;
`ifdef FETCH_PERF_EN
    logic [31:0]        perf_fetch;
    logic [31:0]        perf_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;

    fetch_sequencer dut (
        .CLK           (CLK),
        .Reset_L       (Reset_L),
        .StartPC       (StartPC),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .redirect_valid(redirect_valid),
        .redirect_reg  (redirect_reg),
        .BusImm        (BusImm),
        .BusReg        (BusReg)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch    (perf_fetch),
        .perf_stall    (perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] pc;
        bit                rv;
        bit                rr;
        logic [ADDR_W-1:0] imm;
        logic [ADDR_W-1:0] rg;
        logic [ADDR_W-1:0] expected;
    } vec_t;

    // Reference next-PC from the architectural rules, using word arithmetic rather than shifts.
    function automatic logic [ADDR_W-1:0] modelNext(input logic [ADDR_W-1:0] pc, input bit rv, input bit rr,
                                                    input logic [ADDR_W-1:0] imm, input logic [ADDR_W-1:0] rg);
        logic [ADDR_W-1:0] r;
        if (!rv)      r = pc + 64'd4;
        else if (!rr) r = pc + imm * 64'd4;
        else          r = rg;
        r[1:0] = 2'b00;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic scrambleRedirect();
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_reg   = 1'($urandom_range(0, 1));
        BusImm         = {$urandom, $urandom};
        BusReg         = {$urandom, $urandom};
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"},   imem_req, 0);
        checkOutput({tag, "_addr"},  imem_addr, 0);
        checkOutput({tag, "_valid"}, instr_valid, 0);
        checkOutput({tag, "_instr"}, instr, 0);
        checkOutput({tag, "_ipc"},   instr_pc, 0);
    endtask

    // Reset, release, check the idle BOOT cycle, then the first request at StartPC.
    task automatic applyStimulus(input logic [ADDR_W-1:0] start);
        Reset_L     = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        StartPC     = start;
        tick();
        tick();
        Reset_L = 1'b1;
        checkOutput("boot_req", imem_req, 0);
        tick();
        checkOutput("first_req", imem_req, 1);
        checkOutput("first_addr", imem_addr, start);
    endtask

    task automatic fetchOne(input logic [ADDR_W-1:0] addr, input logic [INSTR_W-1:0] data, input int delay);
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick();
            checkOutput("wait_req", imem_req, 1);
            checkOutput("wait_addr", imem_addr, addr);
            checkOutput("wait_valid", instr_valid, 0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack = 1'b0;
        checkOutput("ack_valid", instr_valid, 1);
        checkOutput("ack_instr", instr, data);
        checkOutput("ack_ipc", instr_pc, addr);
        checkOutput("ack_req", imem_req, 0);
    endtask

    task automatic handshake(input int hold, input bit rv, input bit rr, input logic [ADDR_W-1:0] imm,
                             input logic [ADDR_W-1:0] rg, input logic [INSTR_W-1:0] data,
                             input logic [ADDR_W-1:0] pc);
        for (int i = 0; i < hold; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom_range(0, 1));
            scrambleRedirect();
            tick();
            checkOutput("hold_valid", instr_valid, 1);
            checkOutput("hold_instr", instr, data);
            checkOutput("hold_ipc", instr_pc, pc);
            checkOutput("hold_req", imem_req, 0);
        end
        imem_ack       = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = rv;
        redirect_reg   = rr;
        BusImm         = imm;
        BusReg         = rg;
        tick();
        instr_ready = 1'b0;
        scrambleRedirect();
        checkOutput("hs_valid", instr_valid, 0);
        checkOutput("hs_req", imem_req, 1);
    endtask

    vec_t vecs[7];

    initial begin
        logic [ADDR_W-1:0] pc, nxt, imm, rg;
        logic [INSTR_W-1:0] data;
        bit rv, rr;
        int delay, hold, stalls;

        vecs[0] = '{"seq",        64'h1000,                0, 0, 64'h0,                   64'h0,    64'h1004};
        vecs[1] = '{"rel_neg",    64'h2000,                1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0,    64'h1FF8};
        vecs[2] = '{"br_align",   64'h2000,                1, 1, 64'h0,                   64'h3007, 64'h3004};
        vecs[3] = '{"seq_wrap",   64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0,                   64'h0,    64'h0};
        vecs[4] = '{"imm_trunc",  64'h1000,                1, 0, 64'h4000_0000_0000_0001, 64'h0,    64'h1004};
        vecs[5] = '{"rr_no_rv",   64'h2000,                0, 1, 64'h0,                   64'hDEAD, 64'h2004};
        vecs[6] = '{"rel_wrap",   64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 64'h8,                   64'h0,    64'h10};

        // Reset values while held in reset.
        #2;
        checkResetOutputs("reset");

        foreach (vecs[i]) begin
            data = $urandom;
            applyStimulus(vecs[i].pc);
            fetchOne(vecs[i].pc, data, 0);
            handshake(1, vecs[i].rv, vecs[i].rr, vecs[i].imm, vecs[i].rg, data, vecs[i].pc);
            checkOutput(vecs[i].name, imem_addr, vecs[i].expected);
        end

        // Delayed ack, long HOLD, then sequential next fetch.
        applyStimulus(64'h1000);
        fetchOne(64'h1000, 32'hF800_0001, 3);
`ifdef FETCH_PERF_EN
        checkOutput("perf_stall3", perf_stall, 3);
        checkOutput("perf_fetch0", perf_fetch, 0);
`endif
        handshake(5, 0, 0, 64'h0, 64'h0, 32'hF800_0001, 64'h1000);
`ifdef FETCH_PERF_EN
        checkOutput("perf_fetch1", perf_fetch, 1);
`endif
        checkOutput("seq_after_hold", imem_addr, 64'h1004);

        // Reset mid-request, then an ack pulsed in the BOOT cycle must be ignored.
        Reset_L = 1'b0;
        #1;
        checkResetOutputs("midreset");
`ifdef FETCH_PERF_EN
        checkOutput("midreset_pfetch", perf_fetch, 0);
        checkOutput("midreset_pstall", perf_stall, 0);
`endif
        StartPC = 64'h8000;
        tick();
        Reset_L    = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        checkOutput("late_ack_valid", instr_valid, 0);
        checkOutput("late_ack_req", imem_req, 1);
        checkOutput("late_ack_addr", imem_addr, 64'h8000);
        tick();
        checkOutput("late_ack_still_req", imem_req, 1);
        fetchOne(64'h8000, 32'h1234_5678, 0);
        handshake(0, 1, 1, 64'h0, 64'hABC3, 32'h1234_5678, 64'h8000);
        checkOutput("post_reset_br", imem_addr, 64'hABC0);

        // Randomized transaction stream against the reference model.
        pc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
        applyStimulus(pc);
        stalls = 0;
        for (int n = 0; n < 200; n++) begin
            data  = $urandom;
            delay = $urandom_range(0, 3);
            hold  = $urandom_range(0, 3);
            rv    = 1'($urandom_range(0, 1));
            rr    = 1'($urandom_range(0, 1));
            imm   = {$urandom, $urandom};
            rg    = {$urandom, $urandom};
            stalls += delay;
            fetchOne(pc, data, delay);
            handshake(hold, rv, rr, imm, rg, data, pc);
            nxt = modelNext(pc, rv, rr, imm, rg);
            checkOutput("rand_next_pc", imem_addr, nxt);
            pc = nxt;
        end
`ifdef FETCH_PERF_EN
        checkOutput("rand_perf_fetch", perf_fetch, 200);
        checkOutput("rand_perf_stall", perf_stall, 32'(stalls));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
